l1_dcache_ctrl: RTL and testbench
=================================

Name: l1_dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller between the MEM stage and the next-level memory port.
- Serves MEM-stage loads and stores. It is the producer of the mem_stall signal, which the hazard unit uses to freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- On a miss it runs line writeback and refill over a req/ack line-transfer handshake.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, CPU word width in bits.
- LINE_WORDS, 4, words per line (power of 2).
- NUM_LINES, 16, number of cache lines (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cpu_req  in  1  MEM stage issues a load/store this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  byte address, word-aligned.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_wstrb  in  DATA_WIDTH/8  store byte enables.
- cpu_rdata  out  DATA_WIDTH  load data, valid when cpu_req=1 and mem_stall=0.
- mem_stall  out  1  request cannot complete this cycle; freezes the pipeline.
- mem_req  out  1  line transfer request.
- mem_we  out  1  1 = line writeback, 0 = line fetch.
- mem_addr  out  ADDR_WIDTH  line-aligned address (offset bits zero).
- mem_wdata  out  DATA_WIDTH*LINE_WORDS  victim line data.
- mem_rdata  in  DATA_WIDTH*LINE_WORDS  refill line data, valid with mem_ack.
- mem_ack  in  1  transfer complete. Single-cycle pulse.

Behaviour:
- Address split, LSB first:
  - 2 byte-offset bits (ignored).
  - log2(LINE_WORDS) word-select bits.
  - log2(NUM_LINES) index bits.
  - Tag is the remaining bits.
- Per line storage: valid bit, dirty bit, tag, LINE_WORDS data words.
- hit = cpu_req & valid[idx] & (tag[idx] == addr_tag).
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE, hit:
  - cpu_rdata is driven combinationally from the array in the same cycle; mem_stall=0.
  - Store hit: on the clock edge, merge cpu_wdata into the selected word per cpu_wstrb and set dirty.
  - cpu_wstrb=0 on a store leaves data unchanged but still sets dirty.
- IDLE, miss: mem_stall=1 combinationally in the same cycle.
  - If the victim is valid and dirty, the next state is WRITEBACK with mem_addr = {victim tag, idx, 0}.
  - Otherwise the next state is ALLOCATE with mem_addr = {addr_tag, idx, 0}.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_wdata = victim line.
  - On mem_ack, go to ALLOCATE and clear dirty[idx].
- ALLOCATE:
  - mem_req=1, mem_we=0.
  - On mem_ack, write mem_rdata into the line, set tag, set valid, clear dirty, and return to IDLE.
  - The retried access then hits in IDLE: mem_stall drops and a store merges normally.
- mem_stall is asserted whenever state != IDLE, or in IDLE when cpu_req & ~hit.
- Latency:
  - Hit: 0 stall cycles.
  - Clean miss: stall cycles = cycles from entering ALLOCATE to ack, plus 1.
  - Dirty miss: adds the WRITEBACK duration.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata are registered outputs, held stable from assertion until mem_ack is sampled high.
  - mem_req deasserts in the cycle after ack unless the FSM immediately issues the next transfer (WRITEBACK->ALLOCATE). In that case mem_req stays high and mem_we/mem_addr change at that edge.
  - mem_ack while mem_req=0 is ignored.
  - mem_ack in the same cycle mem_req first rises is accepted (zero-wait memory).
- CPU side: cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_wstrb are held stable while mem_stall=1, because the pipeline is frozen. The controller does not re-latch them.
- cpu_req=0 in IDLE: mem_stall=0, no state change, cpu_rdata=0.
- Reset (async, at any time, including mid-transfer):
  - Clear all valid and dirty bits; state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - mem_stall is forced 0 while rst=1.
  - Dirty data lost in a reset is discarded by design. Tag and data arrays are not required to reset.

Test Plan:
- Cold load 0x0000_0040 after reset, memory acks 3 cycles after mem_req with line {D3,D2,D1,D0} = {0x33,0x22,0x11,0x00} -> mem_req/mem_we=0/mem_addr=0x40; mem_stall high 4 cycles; cpu_rdata=0x00 on release; a following load 0x44 returns 0x11 with 0 stall.
- Store hit 0x48 wdata 0xAABBCCDD, wstrb=4'b0011 over word 0x22 -> a subsequent load 0x48 returns 0x0000CCDD, dirty[4]=1, no mem_req.
- Load 0x0000_0440, same index 4 with a different tag, on the dirty line -> WRITEBACK mem_addr=0x40, mem_we=1, mem_wdata word2=0x0000CCDD. Then ALLOCATE mem_addr=0x440 with mem_req continuous across the transition, then hit.
- Zero-wait memory (mem_ack in the same cycle as mem_req) on a clean miss -> exactly 2 stall cycles; spurious mem_ack while idle causes no state change.
- Store miss 0x80 wdata 0x12345678, wstrb=4'hF -> refill, then merge; line valid and dirty; load 0x80 returns 0x12345678.
- Assert rst during WRITEBACK with mem_req high -> mem_req=0 and mem_stall=0 immediately (async); after release, a load to the previous address misses.

Source files
------------

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 data cache controller.
// Stalls the MEM stage on a miss and moves whole lines over a req/ack port.
module l1_dcache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cpu_req,
  input  logic                             cpu_we,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [DATA_WIDTH-1:0]            cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cpu_wstrb,
  output logic [DATA_WIDTH-1:0]            cpu_rdata,
  output logic                             mem_stall,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH*LINE_WORDS-1:0] mem_wdata,
  input  logic [DATA_WIDTH*LINE_WORDS-1:0] mem_rdata,
  input  logic                             mem_ack
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int BOFF_W = $clog2(NB);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int LO_W   = BOFF_W + OFF_W;
  localparam int TAG_W  = ADDR_WIDTH - LO_W - IDX_W;
  localparam int LINE_W = DATA_WIDTH * LINE_WORDS;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state;

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [LINE_W-1:0]    data_arr [NUM_LINES];

  logic [OFF_W-1:0]  word_sel;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  addr_tag;
  logic [LINE_W-1:0] cur_line;
  logic [LINE_W-1:0] merged_line;
  logic              hit;
  logic              unused;

  assign word_sel = cpu_addr[BOFF_W +: OFF_W];
  assign idx      = cpu_addr[LO_W +: IDX_W];
  assign addr_tag = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign unused   = ^cpu_addr[BOFF_W-1:0];

  assign cur_line = data_arr[idx];
  assign hit      = cpu_req & valid[idx] & (tag_arr[idx] == addr_tag);

  assign cpu_rdata = (state == IDLE && hit)
                   ? cur_line[word_sel*DATA_WIDTH +: DATA_WIDTH]
                   : '0;

  assign mem_stall = ~rst & ((state != IDLE) | (cpu_req & ~hit));

  always_comb begin
    merged_line = cur_line;
    for (int b = 0; b < NB; b++) begin
      if (cpu_wstrb[b])
        merged_line[word_sel*DATA_WIDTH + b*8 +: 8] = cpu_wdata[b*8 +: 8];
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state == ALLOCATE && mem_ack) begin
      data_arr[idx] <= mem_rdata;
      tag_arr[idx]  <= addr_tag;
    end else if (state == IDLE && hit && cpu_we) begin
      data_arr[idx] <= merged_line;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_req && !hit) begin
            mem_req <= 1'b1;
            if (valid[idx] && dirty[idx]) begin
              state     <= WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_arr[idx], idx, {LO_W{1'b0}}};
              mem_wdata <= cur_line;
            end else begin
              state    <= ALLOCATE;
              mem_we   <= 1'b0;
              mem_addr <= {addr_tag, idx, {LO_W{1'b0}}};
            end
          end else if (hit && cpu_we) begin
            dirty[idx] <= 1'b1;
          end
        end
        // mem_req stays high straight into the refill
        WRITEBACK: begin
          if (mem_ack) begin
            state      <= ALLOCATE;
            dirty[idx] <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {addr_tag, idx, {LO_W{1'b0}}};
          end
        end
        ALLOCATE: begin
          if (mem_ack) begin
            state      <= IDLE;
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            mem_req    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Directed bench for l1_dcache_ctrl: misses, hits, writeback,
// zero-wait memory, store-allocate and asynchronous reset.
module tb_l1_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_wstrb;
  logic [31:0]  cpu_rdata;
  logic         mem_stall;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  int errors = 0;
  int checks = 0;

  int           stalls;
  int           nx;
  bit           gap;
  logic [31:0]  rd;
  logic         x_we   [4];
  logic [31:0]  x_addr [4];
  logic [127:0] x_wd   [4];

  l1_dcache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wstrb (cpu_wstrb),
    .cpu_rdata (cpu_rdata),
    .mem_stall (mem_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds a CPU access until released, acking each transfer in its
  // wait_n-th cycle of mem_req, and logs every transfer issued.
  task automatic access(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input int wait_n);
    int rc;
    bit prev_ack;
    bit done;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = wd;
    cpu_wstrb = ws;
    stalls = 0;
    nx = 0;
    gap = 0;
    rc = 0;
    prev_ack = 0;
    done = 0;
    rd = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_stall) begin
        done = 1;
        rd = cpu_rdata;
      end else begin
        stalls++;
        if (mem_req) begin
          if (rc == 0 || prev_ack) begin
            if (nx < 4) begin
              x_we[nx] = mem_we;
              x_addr[nx] = mem_addr;
              x_wd[nx] = mem_wdata;
            end
            nx++;
            rc = 0;
          end
          rc++;
          mem_ack = (rc == wait_n);
        end else if (nx > 0) begin
          gap = 1;
        end
        prev_ack = mem_ack;
      end
    end
    chk("access_done", {127'd0, done}, 128'd1);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_wstrb = '0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'h40;
    cpu_wdata = '0;
    cpu_wstrb = '0;
    mem_rdata = '0;
    mem_ack = 1'b0;

    // reset state, stall forced low even with a request pending
    #12;
    chk("rst_stall", {127'd0, mem_stall}, 128'd0);
    chk("rst_req", {127'd0, mem_req}, 128'd0);
    chk("rst_we", {127'd0, mem_we}, 128'd0);
    chk("rst_addr", {96'd0, mem_addr}, 128'd0);
    chk("rst_wdata", mem_wdata, 128'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_rdata", {96'd0, cpu_rdata}, 128'd0);
    chk("idle_stall", {127'd0, mem_stall}, 128'd0);

    // cold load miss, ack in third request cycle
    mem_rdata = {32'h33, 32'h22, 32'h11, 32'h00};
    access(1'b0, 32'h40, '0, '0, 3);
    chk("cold_nx", nx, 1);
    chk("cold_we", {127'd0, x_we[0]}, 128'd0);
    chk("cold_addr", {96'd0, x_addr[0]}, 128'h40);
    chk("cold_stalls", stalls, 4);
    chk("cold_rdata", {96'd0, rd}, 128'h0);

    access(1'b0, 32'h44, '0, '0, 3);
    chk("hit44_stalls", stalls, 0);
    chk("hit44_rdata", {96'd0, rd}, 128'h11);

    // partial store hit
    access(1'b1, 32'h48, 32'hAABBCCDD, 4'b0011, 3);
    chk("st48_stalls", stalls, 0);
    chk("st48_nx", nx, 0);
    access(1'b0, 32'h48, '0, '0, 3);
    chk("ld48_rdata", {96'd0, rd}, 128'h0000CCDD);
    chk("ld48_nx", nx, 0);

    // conflict miss on the dirty line: writeback then refill
    mem_rdata = {32'h44440003, 32'h44440002, 32'h44440001, 32'h44440000};
    access(1'b0, 32'h440, '0, '0, 2);
    chk("wb_nx", nx, 2);
    chk("wb_we", {127'd0, x_we[0]}, 128'd1);
    chk("wb_addr", {96'd0, x_addr[0]}, 128'h40);
    chk("wb_wdata", x_wd[0], {32'h33, 32'h0000CCDD, 32'h11, 32'h00});
    chk("al_we", {127'd0, x_we[1]}, 128'd0);
    chk("al_addr", {96'd0, x_addr[1]}, 128'h440);
    chk("wb_al_gap", {127'd0, gap}, 128'd0);
    chk("wb_stalls", stalls, 5);
    chk("wb_rdata", {96'd0, rd}, 128'h44440000);

    // zero-wait memory on a clean miss
    mem_rdata = {32'hCCCC0003, 32'hCCCC0002, 32'hCCCC0001, 32'hCCCC0000};
    access(1'b0, 32'hC0, '0, '0, 1);
    chk("zw_stalls", stalls, 2);
    chk("zw_nx", nx, 1);
    chk("zw_rdata", {96'd0, rd}, 128'hCCCC0000);

    // spurious ack while idle
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("spur_req", {127'd0, mem_req}, 128'd0);
    chk("spur_stall", {127'd0, mem_stall}, 128'd0);
    access(1'b0, 32'hC4, '0, '0, 1);
    chk("spur_hit_stalls", stalls, 0);
    chk("spur_hit_rdata", {96'd0, rd}, 128'hCCCC0001);

    // store miss: refill then merge
    mem_rdata = {32'hDDDD0003, 32'hDDDD0002, 32'hDDDD0001, 32'hDDDD0000};
    access(1'b1, 32'h80, 32'h12345678, 4'hF, 2);
    chk("stm_stalls", stalls, 3);
    chk("stm_nx", nx, 1);
    chk("stm_we", {127'd0, x_we[0]}, 128'd0);
    chk("stm_addr", {96'd0, x_addr[0]}, 128'h80);
    access(1'b0, 32'h80, '0, '0, 1);
    chk("stm_ld80", {96'd0, rd}, 128'h12345678);
    access(1'b0, 32'h84, '0, '0, 1);
    chk("stm_ld84", {96'd0, rd}, 128'hDDDD0001);

    // reset in the middle of a writeback
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'h880;
    @(negedge clk);
    chk("mid_miss_stall", {127'd0, mem_stall}, 128'd1);
    @(negedge clk);
    chk("mid_wb_req", {127'd0, mem_req}, 128'd1);
    chk("mid_wb_we", {127'd0, mem_we}, 128'd1);
    chk("mid_wb_addr", {96'd0, mem_addr}, 128'h80);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {127'd0, mem_req}, 128'd0);
    chk("mid_rst_stall", {127'd0, mem_stall}, 128'd0);
    chk("mid_rst_we", {127'd0, mem_we}, 128'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // previously cached and dirty line is gone: clean refill only
    mem_rdata = {32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000};
    access(1'b0, 32'h80, '0, '0, 1);
    chk("post_stalls", stalls, 2);
    chk("post_nx", nx, 1);
    chk("post_we", {127'd0, x_we[0]}, 128'd0);
    chk("post_addr", {96'd0, x_addr[0]}, 128'h80);
    chk("post_rdata", {96'd0, rd}, 128'h55550000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
